// File: rtl/shift_seq_pkg.sv
// Shared constants and types for the shift_seq_32 sequencer.
// Optional macro: SHIFT_SEQ_SELFCHECK_EN enables the single-step shifter
// self-check in shift_seq_32.
package shift_seq_pkg;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_e;

  // One-hot shifter select, bit order {L, NO, R}.
  typedef enum logic [2:0] {
    SEL_L  = 3'b100,
    SEL_NO = 3'b010,
    SEL_R  = 3'b001
  } sel_e;

  // Select the shifter should see while the sequencer sits in state s.
  function automatic sel_e sel_decode(state_e s, logic dir_left);
    sel_e sel;
    sel = SEL_NO;
    if (s == SHIFT) begin
      sel = dir_left ? SEL_L : SEL_R;
    end
    return sel;
  endfunction

endpackage

// File: rtl/shift_sel_drv.sv
// Shifter select driver: turns the sequencer's next state and direction
// into the registered one-hot select and its three complements. The
// selects come straight from flops, so they never glitch on state changes.
module shift_sel_drv
  import shift_seq_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  state_e next_state,
  input  logic   next_dir,
  output logic   l_shift,
  output logic   no_shift,
  output logic   r_shift,
  output logic   left_not,
  output logic   old_not,
  output logic   right_not
);

  sel_e sel_d;
  sel_e sel_q;

  // Decode the select that belongs to the state being entered.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    sel_d = SEL_NO;
    sel_d = sel_decode(next_state, next_dir);
  end

  // Register the select alongside the state so both change on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (reset) begin
      sel_q <= SEL_NO;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign l_shift   = sel_q[2];
  assign no_shift  = sel_q[1];
  assign r_shift   = sel_q[0];
  assign left_not  = ~sel_q[2];
  assign old_not   = ~sel_q[1];
  assign right_not = ~sel_q[0];

endmodule

// File: rtl/shift_seq_32.sv
// Iterative multi-position shift sequencer in front of a 32-bit single-step
// shifter. Holds the operand, drives the shifter select for AMT cycles and
// captures SH_OUT each cycle, giving an AMT-position logical shift.
// Optional macro: SHIFT_SEQ_SELFCHECK_EN -- compares SH_OUT against an
// internal one-position shift during SHIFT and raises sticky ERR on mismatch.
module shift_seq_32
  import shift_seq_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             DIR_LEFT,
  input  logic [AMT_W-1:0] AMT,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic [WIDTH-1:0] SH_OUT,
  output logic [WIDTH-1:0] SH_IN,
  output logic             L_SHIFT,
  output logic             NO_SHIFT,
  output logic             R_SHIFT,
  output logic             LEFT_NOT,
  output logic             OLD_NOT,
  output logic             RIGHT_NOT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             ERR
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] op_q;
  logic [AMT_W-1:0] count_q;
  logic             dir_q;
  logic             dir_d;

  logic             accept;
  assign accept = (state_q == IDLE) && START;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; START only matters in IDLE, exit SHIFT on the last step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (START) state_d = (AMT == '0) ? FIN : SHIFT;
      SHIFT:   if (count_q == AMT_W'(1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand, remaining count and direction: load on accept, step in SHIFT.
  always_ff @(posedge CLK) begin
    // NOTE: the operand register is a plain register, not a memory, so it is reset and SH_IN is 0 out of reset.
    if (RESET) begin
      op_q    <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= DATA_IN;
      count_q <= AMT;
      dir_q   <= DIR_LEFT;
    end else if (state_q == SHIFT) begin
      op_q    <= SH_OUT;
      count_q <= count_q - AMT_W'(1);
    end
  end

  // Direction the select driver must use for the state being entered.
  always_comb begin
    dir_d = accept ? DIR_LEFT : dir_q;
  end

  shift_sel_drv u_sel_drv (
    .clk        (CLK),
    .reset      (RESET),
    .next_state (state_d),
    .next_dir   (dir_d),
    .l_shift    (L_SHIFT),
    .no_shift   (NO_SHIFT),
    .r_shift    (R_SHIFT),
    .left_not   (LEFT_NOT),
    .old_not    (OLD_NOT),
    .right_not  (RIGHT_NOT)
  );

  assign SH_IN  = op_q;
  assign RESULT = op_q;
  assign BUSY   = (state_q == SHIFT);
  assign DONE   = (state_q == FIN);

`ifdef SHIFT_SEQ_SELFCHECK_EN
  logic [WIDTH-1:0] exp_step;
  logic             err_q;

  // Expected single-position result of the downstream stage.
  always_comb begin
    exp_step = dir_q ? (op_q << 1) : (op_q >> 1);
  end

  // Sticky error flag, cleared only by RESET.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else if ((state_q == SHIFT) && (SH_OUT != exp_step)) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule
